// File: rtl/mem_arbiter.sv
// Two-port memory arbiter in front of a single synchronous RAM port.
//
// Each access takes two cycles: the ISSUE cycle drives the RAM port from the winning
// requester, and the RESP cycle pulses that requester's ack and returns the RAM read data.
// In RESP, a pending request on the other port is handed straight to ISSUE, so two
// continuously requesting ports alternate with one access every two cycles.
//
// Parameters:
//   ADDR_W      address width of both requester ports and the memory port
//   DATA_W      width of the write, read and memory data buses
//   FIXED_PRIO  0: round-robin on ties; 1: port 0 wins ties in IDLE
//
// Ports:
//   clock, resetn             clock; asynchronous active-low reset
//   req0/we0/addr0/wdata0     requester 0 request, held until ack0 is sampled high
//   ack0                      requester 0 one-cycle completion pulse
//   req1/we1/addr1/wdata1     requester 1 request, held until ack1 is sampled high
//   ack1                      requester 1 one-cycle completion pulse
//   rdata                     read return, valid only while ack0 or ack1 is high
//   mem_en/mem_we/mem_addr/mem_wdata  RAM command, non-zero only in ISSUE
//   mem_rdata                 RAM read data, valid the cycle after mem_en
//   busy                      high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              resetn,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_owner_q, last_owner_d;
  logic   winner;

  // State register. last_owner resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Winner for arbitration out of IDLE. Only consulted when at least one req is high.
  always_comb begin
    winner = 1'b0;
    if (FIXED_PRIO != 0) begin
      winner = !req0;
    end else if (req0 && req1) begin
      winner = !last_owner_q;
    end else begin
      winner = req1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d = winner;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StResp;
      end
      StResp: begin
        last_owner_d = owner_q;
        // The owner's own req is ignored here; only the other port can chain directly.
        if (owner_q ? req0 : req1) begin
          owner_d = !owner_q;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. ack0/ack1/mem_en come from registers only; the RAM command fields mux the
  // owner's held request inputs.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata     = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIssue: begin
        mem_en    = 1'b1;
        mem_we    = owner_q ? we1    : we0;
        mem_addr  = owner_q ? addr1  : addr0;
        mem_wdata = owner_q ? wdata1 : wdata0;
      end
      StResp: begin
        ack0  = !owner_q;
        ack1  = owner_q;
        rdata = mem_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance and one fixed-priority
// instance share all requester inputs, each with its own synchronous RAM model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;

  logic        ack0, ack1, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic        f_ack0, f_ack1, f_mem_en, f_mem_we, f_busy;
  logic [31:0] f_rdata, f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = !clock;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(f_ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(f_ack1),
    .rdata(f_rdata),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata),
    .busy(f_busy)
  );

  // Synchronous RAM models: address 0x10 reads 0x12345678, others read addr ^ 0xCAFE0000.
  always @(posedge clock) begin
    if (mem_en) mem_rdata <= (mem_addr == 32'h10) ? 32'h12345678 : (mem_addr ^ 32'hCAFE0000);
    if (f_mem_en) begin
      f_mem_rdata <= (f_mem_addr == 32'h10) ? 32'h12345678 : (f_mem_addr ^ 32'hCAFE0000);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic        p;
    logic [31:0] exp_addr;

    resetn = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset state, before any clock edge.
    #3;
    check_eq("rst_outs", {busy, mem_en, mem_we, ack0, ack1, |mem_addr, |mem_wdata, |rdata}, 0);
    check_eq("rst_outs_fp", {f_busy, f_mem_en, f_ack0, f_ack1}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;

    // Idle: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle", {busy, mem_en, mem_we, ack0, ack1, |mem_addr, |mem_wdata, |rdata}, 0);
    end

    // Single write on port 1.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hDEADBEEF;
    tick();
    check_eq("wr_issue_en", {mem_en, mem_we, ack0, ack1, busy}, 5'b11001);
    check_eq("wr_issue_addr", mem_addr, 32'h20);
    check_eq("wr_issue_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    check_eq("wr_resp", {mem_en, mem_we, ack0, ack1, busy}, 5'b00011);
    check_eq("wr_resp_addr", mem_addr, 32'h0);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    check_eq("wr_done", {mem_en, ack0, ack1, busy}, 4'b0000);

    // Single read on port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    tick();
    check_eq("rd_issue", {mem_en, mem_we, ack0, ack1}, 4'b1000);
    check_eq("rd_issue_addr", mem_addr, 32'h10);
    tick();
    check_eq("rd_resp", {mem_en, ack0, ack1}, 3'b010);
    check_eq("rd_rdata", rdata, 32'h12345678);
    req0 = 1'b0;
    tick();
    check_eq("rd_done", {busy, ack0, ack1, |rdata}, 4'b0000);

    // Tie from IDLE after port 0 was last served: round-robin picks 1, fixed picks 0.
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h100; addr1 = 32'h200;
    tick();
    check_eq("tie_rr_addr", mem_addr, 32'h200);
    check_eq("tie_fp_addr", f_mem_addr, 32'h100);
    tick();
    check_eq("tie_rr_ack", {ack0, ack1}, 2'b01);
    check_eq("tie_fp_ack", {f_ack0, f_ack1}, 2'b10);
    check_eq("tie_rr_rdata", rdata, 32'hCAFE0200);

    // Clean restart, then continuous contention from reset.
    req0 = 1'b0; req1 = 1'b0;
    resetn = 1'b0;
    tick();
    @(negedge clock);
    resetn = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("cont_busy", {busy, f_busy}, 2'b11);
      if (k % 2 == 1) begin
        p = ((k - 1) / 2) % 2 == 1;
        exp_addr = p ? 32'h200 : 32'h100;
        check_eq("cont_issue", {mem_en, ack0, ack1}, 3'b100);
        check_eq("cont_issue_addr", mem_addr, exp_addr);
        check_eq("cont_issue_fp_addr", f_mem_addr, exp_addr);
      end else begin
        p = ((k / 2) - 1) % 2 == 1;
        exp_addr = p ? 32'h200 : 32'h100;
        check_eq("cont_ack", {mem_en, ack0, ack1}, {1'b0, !p, p});
        check_eq("cont_ack_fp", {f_mem_en, f_ack0, f_ack1}, {1'b0, !p, p});
        check_eq("cont_rdata", rdata, exp_addr ^ 32'hCAFE0000);
      end
    end

    // Reset during ISSUE aborts the access; held req0 is re-arbitrated after release.
    req1 = 1'b0; we0 = 1'b1;
    tick();
    check_eq("abort_issue", {mem_en, mem_we}, 2'b11);
    resetn = 1'b0;
    #1;
    check_eq("abort_async", {mem_en, mem_we, busy, ack0, ack1, |mem_addr, |mem_wdata}, 0);
    tick();
    check_eq("abort_held", {mem_en, ack0, busy}, 3'b000);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    check_eq("abort_reissue", {mem_en, ack0}, 2'b10);
    tick();
    check_eq("abort_ack", {mem_en, ack0, ack1}, 3'b010);
    req0 = 1'b0; we0 = 1'b0;
    tick();
    check_eq("abort_done", {busy, ack0}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
